forward_ctrl: RTL
=================

FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-index width.
REQ-002 SHALL have parameter STALL_CNT_W, default 16, stall statistics counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port id_valid  input  1  decode stage holds a real instruction.
REQ-006 SHALL have ports id_rs1, id_rs2  input  REG_ADDR_W  decode-stage source registers.
REQ-007 SHALL have ports id_use_rs1, id_use_rs2  input  1  decode instruction actually reads that source.
REQ-008 SHALL have port id_rd  input  REG_ADDR_W  decode-stage destination register.
REQ-009 SHALL have ports id_regwrite, id_memread  input  1  decode instruction writes rd / is a load.
REQ-010 SHALL have port flush  input  1  kill decode and execute instructions (branch redirect).
REQ-011 SHALL have ports fwd_a_sel, fwd_b_sel  output  2  registered operand-mux selects for the execute stage.
REQ-012 SHALL have port stall  output  1  combinational; hold PC and decode register this cycle.
REQ-013 SHALL have port stall_count  output  STALL_CNT_W  saturating count of stall cycles.

Function
REQ-014 SHALL track three internal stage records EX, MEM, WB, each {valid, rd, regwrite, memread}.
REQ-015 SHALL use select encoding 2'b00 register file, 2'b01 EX/MEM result, 2'b10 MEM/WB result; 2'b11 never driven.
REQ-016 SHALL assert stall when id_valid, EX.valid, EX.memread, EX.rd != 0, and EX.rd matches id_rs1 (with id_use_rs1) or id_rs2 (with id_use_rs2).
REQ-017 SHALL force stall low whenever flush is high (flush has priority).
REQ-018 SHALL each cycle shift EX->MEM and MEM->WB unconditionally; WB contents then retire.
REQ-019 SHALL load EX from decode inputs when neither stall nor flush; load a bubble (valid=0) into EX on stall or flush.
REQ-020 SHALL compute next fwd_x_sel at the EX load: 2'b01 if current EX record is valid, regwrite, rd != 0 and rd == source; else 2'b10 if same test passes on current MEM record; else 2'b00.
REQ-021 SHALL give the newer producer (EX record, 2'b01) priority when both match.
REQ-022 SHALL never forward for register index 0, for a source with its use flag low, or from a bubble record.
REQ-023 SHALL drive fwd_a_sel = fwd_b_sel = 2'b00 in any cycle following a bubble load into EX.
REQ-024 SHALL increment stall_count by 1 each cycle stall is high, saturating at all-ones without wrap.
REQ-025 SHALL have one-cycle latency from decode inputs to fwd_x_sel; stall has zero latency.
REQ-026 SHALL produce at most one stall cycle per load-use hazard (the bubble removes the match next cycle).

Reset
REQ-027 SHALL, on reset high at a clock edge, clear EX, MEM, WB valid bits, fwd_a_sel, fwd_b_sel to 2'b00 and stall_count to 0.
REQ-028 SHALL hold stall low while reset is high, regardless of inputs.
REQ-029 SHALL discard any in-flight hazard when reset asserts mid-stall; first post-reset cycle sees empty stages.

Structure
REQ-030 SHALL place select encodings (SEL_RF, SEL_EXMEM, SEL_MEMWB) and the stage-record field layout in the shared core package.
REQ-031 SHALL use one sub-module, fwd_match, comparing one source against one stage record (valid/regwrite/rd!=0/equality); instantiated four times.

Verification
REQ-032 SHALL cover: add x5 then add x6,x5 back-to-back -> fwd_a_sel=2'b01 in consumer's execute cycle, stall never high.
REQ-033 SHALL cover: add x5, nop, sub x7,x0,x5 -> fwd_b_sel=2'b10; a second x5 writer in between -> 2'b01 wins.
REQ-034 SHALL cover: lw x8 then add x9,x8 -> stall high exactly one cycle, then fwd_a_sel=2'b10, stall_count=1.
REQ-035 SHALL cover: writer targeting x0 followed by reader of x0 -> selects stay 2'b00.
REQ-036 SHALL cover: load-use hazard with flush same cycle -> stall low, next selects 2'b00; reset mid-stall -> all outputs zero next cycle.
REQ-037 SHALL cover: force 2^STALL_CNT_W+3 stall cycles -> stall_count holds all-ones.

Source files
------------

// File: rtl/forward_ctrl_pkg.sv
// forward_ctrl_pkg: operand-select encodings and stage-record layout shared by the forwarding unit
package forward_ctrl_pkg;

    typedef enum logic [1:0] {
        SEL_RF    = 2'b00,
        SEL_EXMEM = 2'b01,
        SEL_MEMWB = 2'b10
    } fwd_sel_e;

    // A forwarding record is packed as {rd, regwrite, valid}; rd fills the upper REG_ADDR_W bits
    localparam int REC_VALID    = 0;
    localparam int REC_REGWRITE = 1;
    localparam int REC_RD       = 2;

endpackage

// File: rtl/fwd_match.sv
// fwd_match: does one stage record produce the register one decode source reads
module fwd_match
    import forward_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W+REC_RD-1:0] rec_i,
    input  logic [REG_ADDR_W-1:0]        src_i,
    input  logic                         use_i,
    output logic                         hit_o
);

    logic [REG_ADDR_W-1:0] rd;

    assign rd    = rec_i[REC_RD +: REG_ADDR_W];
    // x0 is hard-wired, bubbles carry nothing, and an unread source needs no bypass
    assign hit_o = use_i && rec_i[REC_VALID] && rec_i[REC_REGWRITE] && (rd != '0) && (rd == src_i);

endmodule

// File: rtl/forward_ctrl.sv
// forward_ctrl: load-use stall detection and registered operand-bypass selects for the execute stage
module forward_ctrl
    import forward_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic [REG_ADDR_W-1:0]  id_rd,
    input  logic                   id_regwrite,
    input  logic                   id_memread,
    input  logic                   flush,
    output logic [1:0]             fwd_a_sel,
    output logic [1:0]             fwd_b_sel,
    output logic                   stall,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int RW = REG_ADDR_W + REC_RD;

    logic [RW-1:0]          ex_q, ex_d, mem_q, id_rec;
    logic                   ex_memread_q, ex_memread_d;
    logic [REG_ADDR_W-1:0]  ex_rd;
    logic                   load;
    logic                   a_ex, a_mem, b_ex, b_mem;
    logic [1:0]             fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

    assign id_rec = {id_rd, id_regwrite, id_valid};
    assign ex_rd  = ex_q[REC_RD +: REG_ADDR_W];

    // A load in EX cannot bypass to the very next instruction; flush and reset both cancel the hazard
    assign stall = !reset && !flush && id_valid && ex_q[REC_VALID] && ex_memread_q && (ex_rd != '0) &&
                   ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    assign load  = id_valid && !stall && !flush;

    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_a_ex  (.rec_i(ex_q),  .src_i(id_rs1), .use_i(id_use_rs1), .hit_o(a_ex));
    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_a_mem (.rec_i(mem_q), .src_i(id_rs1), .use_i(id_use_rs1), .hit_o(a_mem));
    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_b_ex  (.rec_i(ex_q),  .src_i(id_rs2), .use_i(id_use_rs2), .hit_o(b_ex));
    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_b_mem (.rec_i(mem_q), .src_i(id_rs2), .use_i(id_use_rs2), .hit_o(b_mem));

    // Next EX record and selects; the younger producer (in EX now) wins over the one in MEM
    always_comb begin
        ex_d         = load ? id_rec : '0;
        ex_memread_d = load && id_memread;
        fwd_a_d      = !load ? SEL_RF : a_ex ? SEL_EXMEM : a_mem ? SEL_MEMWB : SEL_RF;
        fwd_b_d      = !load ? SEL_RF : b_ex ? SEL_EXMEM : b_mem ? SEL_MEMWB : SEL_RF;
        cnt_d        = (stall && !(&cnt_q)) ? cnt_q + STALL_CNT_W'(1) : cnt_q;
    end

    // Stage shift, select registers and stall statistics; the MEM record retires at the following edge
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q         <= '0;
            ex_memread_q <= 1'b0;
            mem_q        <= '0;
            fwd_a_q      <= SEL_RF;
            fwd_b_q      <= SEL_RF;
            cnt_q        <= '0;
        end else begin
            ex_q         <= ex_d;
            ex_memread_q <= ex_memread_d;
            mem_q        <= ex_q;
            fwd_a_q      <= fwd_a_d;
            fwd_b_q      <= fwd_b_d;
            cnt_q        <= cnt_d;
        end
    end

    assign fwd_a_sel   = fwd_a_q;
    assign fwd_b_sel   = fwd_b_q;
    assign stall_count = cnt_q;

endmodule
